// File: rtl/vec_mem_stage_ctrl.sv
// Vector memory stage sequencer: splits one load/store request into 64-bit chunk
// accesses to the vector memory unit, gathers load data and reports completion or timeout.
module vec_mem_stage_ctrl #(
  parameter int MAX_CHUNKS = 4,
  parameter int CNT_W      = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [31:0]               req_base_addr,
  input  logic [31:0]               req_stride,
  input  logic [CNT_W-1:0]          req_count,
  input  logic [64*MAX_CHUNKS-1:0]  req_store_data,
  output logic                      stall,
  output logic                      mem_start,
  output logic [31:0]               cpu_addr,
  output logic [63:0]               vec_data_in,
  output logic                      wr_en,
  input  logic                      mem_ready,
  input  logic [63:0]               vec_data_out,
  output logic                      wb_valid,
  output logic [64*MAX_CHUNKS-1:0]  wb_data,
  output logic                      timeout_err
);

  localparam int IDX_W = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic [IDX_W-1:0]               last_q;
  logic                           is_store_q;
  logic [31:0]                    addr_q;
  logic [31:0]                    stride_q;
  logic [MAX_CHUNKS-1:0][63:0]    store_q;
  logic [MAX_CHUNKS-1:0][63:0]    wb_q;
  logic [TO_W-1:0]                to_cnt_q;
  logic                           to_err_q;
  logic                           ack_q;

  logic [CNT_W-1:0]               cnt_eff;
  logic [IDX_W-1:0]               last_in;
  logic                           to_hit;
  logic                           last_chunk;

  always_comb begin
    if (req_count == '0)
      cnt_eff = CNT_W'(1);
    else if (req_count > CNT_W'(MAX_CHUNKS))
      cnt_eff = CNT_W'(MAX_CHUNKS);
    else
      cnt_eff = req_count;
  end

  assign last_in    = IDX_W'(cnt_eff - CNT_W'(1));
  assign to_hit     = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign last_chunk = (idx_q == last_q);
  assign wb_data    = wb_q;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // mem_ready is absorbed into ack_q; the cycle after it is the idle gap the
  // unit needs before the next start, and is where the chunk index advances.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    stall       = 1'b1;
    mem_start   = 1'b0;
    cpu_addr    = '0;
    vec_data_in = '0;
    wr_en       = 1'b0;
    wb_valid    = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (req_valid)
          state_d = ISSUE;
      end
      ISSUE: begin
        mem_start   = 1'b1;
        cpu_addr    = addr_q;
        vec_data_in = store_q[idx_q];
        wr_en       = is_store_q;
        state_d     = WAIT_RDY;
      end
      WAIT_RDY: begin
        cpu_addr    = addr_q;
        vec_data_in = store_q[idx_q];
        wr_en       = is_store_q;
        if (ack_q)
          state_d = last_chunk ? DONE : ISSUE;
        else if (!mem_ready && to_hit)
          state_d = DONE;
      end
      DONE: begin
        wb_valid    = 1'b1;
        timeout_err = to_err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      last_q     <= '0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      stride_q   <= '0;
      store_q    <= '0;
      wb_q       <= '0;
      to_cnt_q   <= '0;
      to_err_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            idx_q      <= '0;
            last_q     <= last_in;
            is_store_q <= req_is_store;
            addr_q     <= req_base_addr;
            stride_q   <= req_stride;
            store_q    <= req_store_data;
            wb_q       <= '0;
            to_err_q   <= 1'b0;
            ack_q      <= 1'b0;
          end
        end
        ISSUE: begin
          to_cnt_q <= '0;
          ack_q    <= 1'b0;
        end
        WAIT_RDY: begin
          if (ack_q) begin
            ack_q <= 1'b0;
            if (!last_chunk) begin
              idx_q  <= idx_q + IDX_W'(1);
              addr_q <= addr_q + stride_q;
            end
          end else if (mem_ready) begin
            ack_q <= 1'b1;
            if (!is_store_q)
              wb_q[idx_q] <= vec_data_out;
          end else if (to_hit) begin
            to_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          ack_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stage_ctrl.sv
// Self-checking bench for vec_mem_stage_ctrl: a behavioural memory-unit responder plus
// per-scenario tasks that compare DUT issues and writebacks against a scoreboard.
module tb_vec_mem_stage_ctrl;

  localparam int MAX_CHUNKS = 4;
  localparam int CNT_W      = 3;
  localparam int TIMEOUT    = 64;
  localparam int DW         = 64 * MAX_CHUNKS;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [31:0]      req_base_addr;
  logic [31:0]      req_stride;
  logic [CNT_W-1:0] req_count;
  logic [DW-1:0]    req_store_data;
  logic             stall;
  logic             mem_start;
  logic [31:0]      cpu_addr;
  logic [63:0]      vec_data_in;
  logic             wr_en;
  logic             mem_ready = 1'b0;
  logic [63:0]      vec_data_out = '0;
  logic             wb_valid;
  logic [DW-1:0]    wb_data;
  logic             timeout_err;

  always #5 clk = ~clk;

  vec_mem_stage_ctrl #(
    .MAX_CHUNKS(MAX_CHUNKS),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_base_addr (req_base_addr),
    .req_stride    (req_stride),
    .req_count     (req_count),
    .req_store_data(req_store_data),
    .stall         (stall),
    .mem_start     (mem_start),
    .cpu_addr      (cpu_addr),
    .vec_data_in   (vec_data_in),
    .wr_en         (wr_en),
    .mem_ready     (mem_ready),
    .vec_data_out  (vec_data_out),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .timeout_err   (timeout_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic        we;
  } iss_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          terr;
    logic [31:0]   cyc;
  } wb_t;

  iss_t        exp_iss_q[$];
  wb_t         exp_wb_q[$];
  logic [63:0] rd_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;

  int          model_lat   = 2;
  bit          model_mute  = 1'b0;
  bit          stray_ready = 1'b0;
  int          pend_cnt    = 0;
  logic [63:0] pend_data   = '0;

  // Memory-unit responder: mem_ready arrives model_lat cycles after the mem_start cycle.
  always @(negedge clk) begin
    if (reset) begin
      pend_cnt  = 0;
      mem_ready = 1'b0;
    end else begin
      mem_ready    = 1'b0;
      vec_data_out = {$urandom, $urandom};
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_ready    = 1'b1;
          vec_data_out = pend_data;
        end
      end
      if (mem_start && !model_mute) begin
        pend_cnt  = model_lat;
        pend_data = (rd_q.size() > 0) ? rd_q.pop_front() : 64'h0;
      end
      if (stray_ready) begin
        mem_ready   = 1'b1;
        stray_ready = 1'b0;
      end
    end
  end

  // Pushes the expected issues/writeback, then performs the request handshake.
  task automatic drive_req(input logic st, input logic [31:0] base, input logic [31:0] stride,
                           input logic [CNT_W-1:0] cnt, input logic [DW-1:0] sdata,
                           input logic [DW-1:0] ldata, input bit exp_to);
    int   n;
    iss_t e;
    wb_t  w;
    bit   got;
    n      = (cnt == 0) ? 1 : ((int'(cnt) > MAX_CHUNKS) ? MAX_CHUNKS : int'(cnt));
    w.data = '0;
    for (int i = 0; i < n; i++) begin
      e.addr = base + stride * 32'(i);
      e.data = sdata[64*i +: 64];
      e.we   = st;
      exp_iss_q.push_back(e);
      if (!st && !exp_to) begin
        rd_q.push_back(ldata[64*i +: 64]);
        w.data[64*i +: 64] = ldata[64*i +: 64];
      end
    end
    w.terr = exp_to;
    w.cyc  = exp_to ? 32'(TIMEOUT + 2) : 32'(n * (model_lat + 2) + 1);
    exp_wb_q.push_back(w);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_wait got 0 exp 1");
    end
    req_valid      = 1'b1;
    req_is_store   = st;
    req_base_addr  = base;
    req_stride     = stride;
    req_count      = cnt;
    req_store_data = sdata;
    @(posedge clk);
    #1 req_valid   = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall); end
    n_cmp++; if ({mem_start, wr_en, wb_valid, timeout_err} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_ctrl got %b exp 0000", {mem_start, wr_en, wb_valid, timeout_err});
    end
    n_cmp++; if ({cpu_addr, vec_data_in} !== 96'h0) begin
      n_bad++; $display("FAIL rst_bus got %h exp 0", {cpu_addr, vec_data_in});
    end
    n_cmp++; if (wb_data !== '0) begin n_bad++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_load;
    logic [31:0]   bases[2]   = '{32'h0000_0100, 32'hFFFF_FFFE};
    logic [31:0]   strides[2] = '{32'h0, 32'h4};
    logic [CNT_W-1:0] cnts[2] = '{3'd1, 3'd2};
    int            lats[2]    = '{2, 4};
    logic [DW-1:0] ld[2];
    logic [DW-1:0] held;
    iss_t e;
    wb_t  w;
    bit   done;
    ld[0] = {192'h0, 64'hDEADBEEF_CAFEF00D};
    ld[1] = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    for (int t = 0; t < 2; t++) begin
      model_lat = lats[t];
      drive_req(1'b0, bases[t], strides[t], cnts[t], '0, ld[t], 1'b0);
      done = 1'b0;
      for (int n = 1; n <= 200 && !done; n++) begin
        @(negedge clk);
        if (mem_start) begin
          n_cmp++;
          if (exp_iss_q.size() == 0) begin
            n_bad++; $display("FAIL ld%0d_extra_start got addr %h exp none", t, cpu_addr);
          end else begin
            e = exp_iss_q.pop_front();
            if ({cpu_addr, wr_en} !== {e.addr, e.we}) begin
              n_bad++; $display("FAIL ld%0d_issue got %h/%b exp %h/%b", t, cpu_addr, wr_en, e.addr, e.we);
            end
          end
        end
        if (wb_valid) begin
          done = 1'b1;
          w = exp_wb_q.pop_front();
          n_cmp++; if (wb_data !== w.data) begin n_bad++; $display("FAIL ld%0d_wb_data got %h exp %h", t, wb_data, w.data); end
          n_cmp++; if (timeout_err !== w.terr) begin n_bad++; $display("FAIL ld%0d_terr got %b exp %b", t, timeout_err, w.terr); end
          n_cmp++; if (32'(n) !== w.cyc) begin n_bad++; $display("FAIL ld%0d_latency got %0d exp %0d", t, n, w.cyc); end
        end
      end
      if (!done) begin n_cmp++; n_bad++; $display("FAIL ld%0d_wb_timeout got none exp wb_valid", t); end
      n_cmp++; if (exp_iss_q.size() !== 0) begin n_bad++; $display("FAIL ld%0d_missing_starts got %0d left exp 0", t, exp_iss_q.size()); end
      held = ld[t] & ((t == 0) ? {192'h0, {64{1'b1}}} : {128'h0, {128{1'b1}}});
      repeat (3) @(negedge clk);
      n_cmp++; if (wb_data !== held) begin n_bad++; $display("FAIL ld%0d_wb_hold got %h exp %h", t, wb_data, held); end
    end
  endtask

  task automatic test_store_multi;
    logic [DW-1:0] sd;
    iss_t e;
    wb_t  w;
    bit   done, busy;
    int   stall_bad, held_bad, starts;
    logic [31:0] h_addr;
    logic [63:0] h_data;
    sd = {64'h0, 64'hCCCC_0003_CCCC_0003, 64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
    model_lat = 3;
    drive_req(1'b1, 32'h40, 32'h4, 3'd3, sd, '0, 1'b0);
    done = 1'b0; busy = 1'b0; stall_bad = 0; held_bad = 0; starts = 0;
    h_addr = '0; h_data = '0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (stall !== 1'b1) stall_bad++;
      if (mem_start) begin
        starts++;
        busy = 1'b1;
        h_addr = cpu_addr;
        h_data = vec_data_in;
        n_cmp++;
        if (exp_iss_q.size() == 0) begin
          n_bad++; $display("FAIL st_extra_start got addr %h exp none", cpu_addr);
        end else begin
          e = exp_iss_q.pop_front();
          if ({cpu_addr, vec_data_in, wr_en} !== {e.addr, e.data, e.we}) begin
            n_bad++; $display("FAIL st_issue%0d got %h/%h/%b exp %h/%h/%b", starts, cpu_addr, vec_data_in, wr_en, e.addr, e.data, e.we);
          end
        end
      end else if (busy && !wb_valid) begin
        if ({cpu_addr, vec_data_in, wr_en} !== {h_addr, h_data, 1'b1}) held_bad++;
      end
      if (wb_valid) begin
        done = 1'b1;
        w = exp_wb_q.pop_front();
        n_cmp++; if (wb_data !== w.data) begin n_bad++; $display("FAIL st_wb_data got %h exp %h", wb_data, w.data); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL st_terr got %b exp 0", timeout_err); end
        n_cmp++; if (32'(n) !== w.cyc) begin n_bad++; $display("FAIL st_latency got %0d exp %0d", n, w.cyc); end
      end
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL st_wb_timeout got none exp wb_valid"); end
    n_cmp++; if (starts !== 3) begin n_bad++; $display("FAIL st_start_count got %0d exp 3", starts); end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL st_stall got %0d low cycles exp 0", stall_bad); end
    n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL st_hold got %0d unstable cycles exp 0", held_bad); end
    @(negedge clk);
    n_cmp++; if ({stall, req_ready} !== 2'b01) begin n_bad++; $display("FAIL st_after got %b exp 01", {stall, req_ready}); end
  endtask

  task automatic test_timeout;
    iss_t e;
    wb_t  w;
    bit   done;
    model_mute = 1'b1;
    drive_req(1'b0, 32'h200, 32'h1, 3'd1, '0, '0, 1'b1);
    done = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (mem_start) begin
        e = exp_iss_q.pop_front();
        n_cmp++; if (cpu_addr !== e.addr) begin n_bad++; $display("FAIL to_addr got %h exp %h", cpu_addr, e.addr); end
      end
      if (wb_valid) begin
        done = 1'b1;
        w = exp_wb_q.pop_front();
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_terr got %b exp 1", timeout_err); end
        n_cmp++; if (32'(n) !== w.cyc) begin n_bad++; $display("FAIL to_latency got %0d exp %0d", n, w.cyc); end
        n_cmp++; if (wb_data !== '0) begin n_bad++; $display("FAIL to_wb_data got %h exp 0", wb_data); end
      end
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL to_wb_timeout got none exp wb_valid"); end
    @(negedge clk);
    n_cmp++; if ({req_ready, timeout_err} !== 2'b10) begin n_bad++; $display("FAIL to_after got %b exp 10", {req_ready, timeout_err}); end
    model_mute = 1'b0;
  endtask

  task automatic test_reset_mid;
    int starts, leaks;
    model_lat = 3;
    drive_req(1'b0, 32'h300, 32'h8, 3'd4, '0, {4{64'h0123_4567_89AB_CDEF}}, 1'b0);
    starts = 0;
    for (int n = 0; n < 100 && starts < 2; n++) begin
      @(negedge clk);
      if (mem_start) starts++;
    end
    n_cmp++; if (starts !== 2) begin n_bad++; $display("FAIL rm_reach_chunk1 got %0d starts exp 2", starts); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, stall, mem_start, wb_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL rm_idle got %b exp 1000", {req_ready, stall, mem_start, wb_valid});
    end
    n_cmp++; if (wb_data !== '0) begin n_bad++; $display("FAIL rm_wb_data got %h exp 0", wb_data); end
    @(posedge clk);
    #1 reset = 1'b0;
    leaks = 0;
    repeat (20) begin
      @(negedge clk);
      if (wb_valid || mem_start || !req_ready) leaks++;
    end
    n_cmp++; if (leaks !== 0) begin n_bad++; $display("FAIL rm_no_wb got %0d active cycles exp 0", leaks); end
    exp_iss_q.delete();
    exp_wb_q.delete();
    rd_q.delete();
  endtask

  task automatic test_count_clamp;
    logic [CNT_W-1:0] cnts[2]   = '{3'd0, 3'd7};
    int               exp_st[2] = '{1, 4};
    int   starts, bad;
    iss_t e;
    wb_t  w;
    bit   done;
    stray_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb_valid || mem_start || !req_ready) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL cc_stray_ready got %0d active cycles exp 0", bad); end
    model_lat = 1;
    for (int t = 0; t < 2; t++) begin
      drive_req(1'b1, 32'h1000, 32'h10, cnts[t], {DW/32{32'h5A5A_0000 + 32'(t)}}, '0, 1'b0);
      done = 1'b0; starts = 0;
      for (int n = 1; n <= 200 && !done; n++) begin
        @(negedge clk);
        if (mem_start) begin
          starts++;
          if (exp_iss_q.size() != 0) begin
            e = exp_iss_q.pop_front();
            n_cmp++; if ({cpu_addr, vec_data_in} !== {e.addr, e.data}) begin
              n_bad++; $display("FAIL cc%0d_issue got %h/%h exp %h/%h", t, cpu_addr, vec_data_in, e.addr, e.data);
            end
          end
        end
        if (wb_valid) begin
          done = 1'b1;
          w = exp_wb_q.pop_front();
          n_cmp++; if (32'(n) !== w.cyc) begin n_bad++; $display("FAIL cc%0d_latency got %0d exp %0d", t, n, w.cyc); end
        end
      end
      if (!done) begin n_cmp++; n_bad++; $display("FAIL cc%0d_wb_timeout got none exp wb_valid", t); end
      n_cmp++; if (starts !== exp_st[t]) begin n_bad++; $display("FAIL cc%0d_starts got %0d exp %0d", t, starts, exp_st[t]); end
      exp_iss_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_is_store   = 1'b0;
    req_base_addr  = '0;
    req_stride     = '0;
    req_count      = '0;
    req_store_data = '0;
    test_reset();
    test_load();
    test_store_multi();
    test_timeout();
    test_reset_mid();
    test_count_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_stage_ctrl.md
Name: vec_mem_stage_ctrl

Overview:
- Pipeline-side sequencer for the vector memory path. Sits directly upstream of the 64-bit vector data-memory unit (the two-word RAM access unit).
- Accepts one vector load/store of 1..MAX_CHUNKS 64-bit chunks from the execute stage, with a base address and a word stride. Issues one chunk at a time to the vector memory unit and stalls the pipeline while busy.
- Gathers load data into a writeback register and flags a timeout if the unit never answers.

Parameters:
- MAX_CHUNKS, 4, maximum number of 64-bit chunks per request.
- CNT_W, 3, width of req_count; must hold MAX_CHUNKS.
- TIMEOUT, 64, cycles to wait for mem_ready per chunk before aborting.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  controller can accept a request (IDLE state).
- req_is_store  in  1  1 = store, 0 = load.
- req_base_addr  in  32  word address of chunk 0.
- req_stride  in  32  word distance between chunk starts; each chunk uses addr and addr+1.
- req_count  in  CNT_W  number of chunks; 0 is treated as 1; values above MAX_CHUNKS are clamped to MAX_CHUNKS.
- req_store_data  in  64*MAX_CHUNKS  chunk i = bits [64i+63:64i].
- stall  out  1  high while a request is in flight (any state except IDLE).
- mem_start  out  1  one-cycle start pulse to the vector memory unit.
- cpu_addr  out  32  chunk address to the unit; held stable from the mem_start cycle until mem_ready.
- vec_data_in  out  64  store data for the current chunk; held like cpu_addr.
- wr_en  out  1  1 for stores; held like cpu_addr.
- mem_ready  in  1  one-cycle completion pulse from the unit.
- vec_data_out  in  64  load data from the unit; valid in the mem_ready cycle.
- wb_valid  out  1  one-cycle pulse when the request completes or aborts.
- wb_data  out  64*MAX_CHUNKS  gathered load data; chunks not loaded read 0.
- timeout_err  out  1  high together with wb_valid when the request aborted.

Behaviour:
- Reset: state=IDLE, chunk index=0, timeout counter=0. Outputs: req_ready=1, stall=0, mem_start=0, wr_en=0, cpu_addr=0, vec_data_in=0, wb_valid=0, wb_data=0, timeout_err=0.
- Reset mid-operation returns to IDLE within one cycle; no wb_valid is produced. The downstream unit shares the same reset.
- States: IDLE, ISSUE, WAIT_RDY, DONE.
- IDLE:
  - When req_valid is high, latch all req_* inputs, clear wb_data and set index=0, then go to ISSUE.
  - req_ready is high only in IDLE. The handshake completes in the cycle req_valid is high in IDLE.
- ISSUE:
  - Drive mem_start=1 for this cycle only.
  - cpu_addr = base + index*stride, computed modulo 2^32 (wraps silently).
  - vec_data_in = latched chunk[index]; wr_en = is_store.
  - Clear the timeout counter, then go to WAIT_RDY.
- WAIT_RDY:
  - mem_start=0; cpu_addr, vec_data_in and wr_en stay held. The counter increments each cycle.
  - On mem_ready: for a load, write vec_data_out into wb_data chunk[index]; stores leave wb_data unchanged.
    - If index == count-1, go to DONE.
    - Otherwise increment index and go to ISSUE. There is one idle cycle between mem_ready and the next mem_start, so the unit can return to its wait state first.
  - If the counter reaches TIMEOUT-1 without mem_ready, set timeout_err and go to DONE.
- DONE:
  - wb_valid=1 for one cycle, timeout_err as set, wr_en=0, then go to IDLE.
  - wb_data is held until the next request is accepted.
- mem_ready seen outside WAIT_RDY is ignored.
- mem_ready in the same cycle the counter reaches TIMEOUT-1 counts as success; mem_ready has priority.
- Latency per request: count*(L+2) + 1 cycles from acceptance to wb_valid, where L is the unit's mem_start-to-mem_ready latency.

Test Plan:
- Load, count=1, base=0x100, stride=0, unit model returns 0xDEADBEEF_CAFEF00D -> one mem_start with cpu_addr=0x100, wr_en=0; wb_valid with wb_data[63:0]=0xDEADBEEFCAFEF00D, upper chunks 0, timeout_err=0.
- Store, count=3, base=0x40, stride=4, data chunks A/B/C -> three mem_start pulses with cpu_addr 0x40/0x44/0x48, vec_data_in A/B/C, wr_en=1 throughout; stall high until wb_valid.
- Load, count=2, base=0xFFFFFFFE, stride=4 -> second cpu_addr=0x00000002 (wrap); both chunks land in wb_data [63:0] and [127:64].
- Unit never asserts mem_ready -> wb_valid and timeout_err both high TIMEOUT+1 cycles after mem_start; then req_ready=1.
- Reset asserted in WAIT_RDY of chunk 1 of 4 -> next cycle state IDLE, stall=0, mem_start=0, no wb_valid.
- req_count=0 and req_count=7 -> exactly 1 and exactly 4 mem_start pulses respectively; a stray mem_ready pulse in IDLE is ignored.
